// File: rtl/start_det_pkg.sv
// Shared types and default thresholds for the start-run detector.
package start_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_READY = 2'd2,
        ST_HOLD  = 2'd3
    } det_state_t;

    localparam int DEF_THRESH  = 4;
    localparam int DEF_RELEASE = 1;

endpackage

// File: rtl/start_det_channel.sv
// One detector channel: debounces a start level with entry threshold, release
// hysteresis, a one-cycle detect pulse and a saturating run-length count.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | start low, no run in progress
//   COUNT    | start high, fewer than THRESH consecutive samples
//   READY    | qualified, detector_out high
//   HOLD     | start low after READY, waiting RELEASE low samples
module start_det_channel
    import start_det_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int THRESH  = DEF_THRESH,
    parameter int RELEASE = DEF_RELEASE
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    output logic             detector_out,
    output logic             detect_pulse,
    output logic [CNT_W-1:0] run_count
);

    localparam logic [CNT_W-1:0] THR_LAST = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE - 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    if (THRESH < 1 || THRESH > (1 << CNT_W) - 1) begin : g_bad_thresh
        $error("start_det_channel: THRESH out of range for CNT_W");
    end
    if (RELEASE < 1 || RELEASE > (1 << CNT_W) - 1) begin : g_bad_release
        $error("start_det_channel: RELEASE out of range for CNT_W");
    end

    det_state_t       state;
    logic [CNT_W-1:0] low;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            run_count    <= '0;
            low          <= '0;
            detector_out <= 1'b0;
            detect_pulse <= 1'b0;
        end else begin
            // The pulse lives for exactly one cycle, even if enable drops.
            detect_pulse <= 1'b0;
            if (enable) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            run_count <= ONE;
                            if (THRESH == 1) begin
                                state        <= ST_READY;
                                detector_out <= 1'b1;
                                detect_pulse <= 1'b1;
                            end else begin
                                state <= ST_COUNT;
                            end
                        end else begin
                            run_count <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (!start) begin
                            state     <= ST_IDLE;
                            run_count <= '0;
                        end else if (run_count == THR_LAST) begin
                            state        <= ST_READY;
                            run_count    <= run_count + ONE;
                            detector_out <= 1'b1;
                            detect_pulse <= 1'b1;
                        end else begin
                            run_count <= run_count + ONE;
                        end
                    end
                    ST_READY: begin
                        if (start) begin
                            if (run_count != RUN_MAX)
                                run_count <= run_count + ONE;
                        end else begin
                            run_count <= '0;
                            if (RELEASE == 1) begin
                                state        <= ST_IDLE;
                                detector_out <= 1'b0;
                            end else begin
                                state <= ST_HOLD;
                                low   <= ONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (start) begin
                            state     <= ST_READY;
                            low       <= '0;
                            run_count <= ONE;
                        end else if (low == REL_LAST) begin
                            state        <= ST_IDLE;
                            low          <= '0;
                            detector_out <= 1'b0;
                        end else begin
                            low <= low + ONE;
                        end
                    end
                    default: begin
                        state        <= ST_IDLE;
                        run_count    <= '0;
                        low          <= '0;
                        detector_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/start_run_detector.sv
// Multi-channel start-run detector: one independent channel per start bit,
// plus an OR of all ready levels.
module start_run_detector
    import start_det_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    parameter int THRESH   = DEF_THRESH,
    parameter int RELEASE  = DEF_RELEASE
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       start,
    output logic [CHANNELS-1:0]       detector_out,
    output logic [CHANNELS-1:0]       detect_pulse,
    output logic [CHANNELS*CNT_W-1:0] run_count,
    output logic                      any_ready
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        start_det_channel #(
            .CNT_W   (CNT_W),
            .THRESH  (THRESH),
            .RELEASE (RELEASE)
        ) u_ch (
            .clock        (clock),
            .reset_n      (reset_n),
            .enable       (enable),
            .start        (start[i]),
            .detector_out (detector_out[i]),
            .detect_pulse (detect_pulse[i]),
            .run_count    (run_count[i*CNT_W +: CNT_W])
        );
    end

    assign any_ready = |detector_out;

endmodule

// File: tb/tb_start_run_detector.sv
// Directed bench: default 4-channel instance plus a single-channel RELEASE=3 instance.
module tb_start_run_detector;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  start_a;
    logic [3:0]  det_a, pulse_a;
    logic [15:0] run_a;
    logic        any_a;
    logic [0:0]  start_b;
    logic [0:0]  det_b, pulse_b;
    logic [3:0]  run_b;
    logic        any_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    start_run_detector u_dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .start        (start_a),
        .detector_out (det_a),
        .detect_pulse (pulse_a),
        .run_count    (run_a),
        .any_ready    (any_a)
    );

    start_run_detector #(.CHANNELS(1), .RELEASE(3)) u_dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .start        (start_b),
        .detector_out (det_b),
        .detect_pulse (pulse_b),
        .run_count    (run_b),
        .any_ready    (any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        start_a = 4'b0000;
        start_b = 1'b0;
        #1;
        chk("reset_det", {28'd0, det_a}, 32'h0);
        chk("reset_run", {16'd0, run_a}, 32'h0);
        chk("reset_any", {31'd0, any_a}, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        enable  = 1'b1;

        // Basic qualification on channel 0
        start_a = 4'b0001;
        step(); chk("t1_run1", {28'd0, run_a[3:0]}, 32'd1);
        step(); chk("t1_run2", {28'd0, run_a[3:0]}, 32'd2);
        step(); chk("t1_run3", {28'd0, run_a[3:0]}, 32'd3);
        chk("t1_det_pre", {28'd0, det_a}, 32'h0);
        step();
        chk("t1_det", {28'd0, det_a}, 32'h1);
        chk("t1_pulse", {28'd0, pulse_a}, 32'h1);
        chk("t1_run4", {28'd0, run_a[3:0]}, 32'd4);
        chk("t1_any", {31'd0, any_a}, 32'h1);
        step();
        chk("t1_pulse_off", {28'd0, pulse_a}, 32'h0);
        chk("t1_run5", {28'd0, run_a[3:0]}, 32'd5);
        start_a = 4'b0000;
        step();
        chk("t1_drop_det", {28'd0, det_a}, 32'h0);
        chk("t1_drop_run", {28'd0, run_a[3:0]}, 32'd0);
        chk("t1_drop_any", {31'd0, any_a}, 32'h0);

        // Broken run: 3 high, 1 low, 2 high
        start_a = 4'b0001;
        step(); chk("t2_r1", {28'd0, run_a[3:0]}, 32'd1);
        step(); chk("t2_r2", {28'd0, run_a[3:0]}, 32'd2);
        step(); chk("t2_r3", {28'd0, run_a[3:0]}, 32'd3);
        start_a = 4'b0000;
        step(); chk("t2_r0", {28'd0, run_a[3:0]}, 32'd0);
        start_a = 4'b0001;
        step(); chk("t2_r1b", {28'd0, run_a[3:0]}, 32'd1);
        step(); chk("t2_r2b", {28'd0, run_a[3:0]}, 32'd2);
        chk("t2_det", {28'd0, det_a}, 32'h0);
        start_a = 4'b0000;
        step(); chk("t2_clear", {28'd0, run_a[3:0]}, 32'd0);

        // Enable freeze mid-count
        start_a = 4'b0001;
        step(); step(); step();
        chk("t4_run3", {28'd0, run_a[3:0]}, 32'd3);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_frz_run", {28'd0, run_a[3:0]}, 32'd3);
            chk("t4_frz_det", {28'd0, det_a}, 32'h0);
            chk("t4_frz_pulse", {28'd0, pulse_a}, 32'h0);
        end
        enable = 1'b1;
        step();
        chk("t4_det", {28'd0, det_a}, 32'h1);
        chk("t4_pulse", {28'd0, pulse_a}, 32'h1);
        chk("t4_run4", {28'd0, run_a[3:0]}, 32'd4);
        enable = 1'b0;
        step();
        chk("t4_pulse_en0", {28'd0, pulse_a}, 32'h0);
        chk("t4_det_hold", {28'd0, det_a}, 32'h1);
        chk("t4_run_hold", {28'd0, run_a[3:0]}, 32'd4);

        // Async reset with ch0 READY and ch1 COUNT at run 2
        enable  = 1'b1;
        start_a = 4'b0011;
        step(); step();
        chk("t5_pre_run1", {28'd0, run_a[7:4]}, 32'd2);
        chk("t5_pre_det", {28'd0, det_a}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_det", {28'd0, det_a}, 32'h0);
        chk("t5_rst_run", {16'd0, run_a}, 32'h0);
        chk("t5_rst_any", {31'd0, any_a}, 32'h0);
        chk("t5_rst_pulse", {28'd0, pulse_a}, 32'h0);
        #1 reset_n = 1'b1;
        step(); step(); step();
        chk("t5_run3", {16'd0, run_a}, 32'h0033);
        chk("t5_det_pre", {28'd0, det_a}, 32'h0);
        step();
        chk("t5_det", {28'd0, det_a}, 32'h3);
        chk("t5_pulse", {28'd0, pulse_a}, 32'h3);
        start_a = 4'b0000;
        step();
        chk("t5_clear", {28'd0, det_a}, 32'h0);

        // Independent channels: ch0 toggles, ch2 high 5 edges, ch3 high 20 edges
        for (int k = 1; k <= 20; k++) begin
            start_a = {1'b1, (k <= 5), 1'b0, k[0]};
            step();
            chk("t6_run3", {28'd0, run_a[15:12]}, (k > 15) ? 32'd15 : k);
            chk("t6_run0", {28'd0, run_a[3:0]}, {31'd0, k[0]});
            chk("t6_det", {28'd0, det_a}, {28'd0, (k >= 4), (k >= 4 && k <= 5), 2'b00});
            chk("t6_pulse", {28'd0, pulse_a}, (k == 4) ? 32'hC : 32'h0);
        end
        start_a = 4'b0000;
        step();

        // Release hysteresis on the RELEASE=3 instance
        start_b = 1'b1;
        step(); step(); step(); step();
        chk("t3_det", {31'd0, det_b}, 32'h1);
        chk("t3_pulse", {31'd0, pulse_b}, 32'h1);
        start_b = 1'b0;
        step();
        chk("t3_hold1", {31'd0, det_b}, 32'h1);
        chk("t3_hold1_run", {28'd0, run_b}, 32'd0);
        step();
        chk("t3_hold2", {31'd0, det_b}, 32'h1);
        start_b = 1'b1;
        step();
        chk("t3_reenter_det", {31'd0, det_b}, 32'h1);
        chk("t3_reenter_pulse", {31'd0, pulse_b}, 32'h0);
        chk("t3_reenter_run", {28'd0, run_b}, 32'd1);
        start_b = 1'b0;
        step(); chk("t3_low1", {31'd0, det_b}, 32'h1);
        step(); chk("t3_low2", {31'd0, det_b}, 32'h1);
        step();
        chk("t3_low3", {31'd0, det_b}, 32'h0);
        chk("t3_any", {31'd0, any_b}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
